mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative, parametrised RISC-V M-extension execute unit covering MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU at XLEN bits.
- Sits beside the combinational ALU in the EX stage and replaces its single-cycle MUL/DIV path.
- Uses a valid/ready handshake on both input and output, so the pipeline stalls while the unit is busy.
- Radix-2 shift-add multiply and restoring divide, both working on operand magnitudes with a final sign fix-up.

Parameters:
- XLEN, 64, operand and result width; legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- In_Valid  input  1  an operation is presented on Func3/A/B.
- In_Ready  output  1  the unit can accept an operation (high only in IDLE).
- Func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  input  XLEN  rs1 (multiplicand or dividend).
- B  input  XLEN  rs2 (multiplier or divisor).
- Flush  input  1  synchronous abort of any in-flight operation.
- Out_Valid  output  1  Result is valid.
- Out_Ready  input  1  the consumer takes Result.
- Result  output  XLEN  the operation result.
- DivZero  output  1  the divisor was zero on a DIV/DIVU/REM/REMU; qualified by Out_Valid.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - State goes to IDLE.
  - In_Ready=1, Out_Valid=0, Result=0, DivZero=0.
  - Counter and datapath registers clear.
  - Reset mid-operation discards the operation; no Out_Valid is produced.
- States are IDLE, CALC and DONE.
- IDLE:
  - In_Ready=1.
  - On an edge with In_Valid&&In_Ready, latch Func3, the sign flags and the magnitudes |A| and |B|.
  - Signed-ness per operand follows Func3: MULHSU treats A as signed and B as unsigned; the *U ops treat both as unsigned.
  - Counter is loaded with XLEN; the next state is CALC.
- Special-case divide (decided at accept, skips CALC, next state DONE):
  - B==0:
    - DIV/DIVU give all-ones.
    - REM/REMU give A.
    - DivZero=1.
  - Signed overflow (DIV/REM with A=most-negative and B=all-ones):
    - DIV gives A.
    - REM gives 0.
    - DivZero=0.
- CALC:
  - One iteration per cycle; counter decrements; when the counter reaches 1, the next state is DONE.
  - Multiply: 2*XLEN-bit product register; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: shift the remainder/quotient pair left by 1; trial-subtract the divisor; on a non-negative result set the quotient bit to 1.
- On entering DONE:
  - Result register loads the selected result.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product.
  - The product is two's-complement negated if the result sign is negative.
  - The quotient is negated if the operand signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
- Latency:
  - Normal operation: Out_Valid rises XLEN+1 cycles after the accept edge.
  - Special cases: Out_Valid rises 1 cycle after the accept edge.
- DONE:
  - Out_Valid=1; Result and DivZero are held stable while Out_Ready=0 (backpressure of any length).
  - On an edge with Out_Valid&&Out_Ready, the next state is IDLE and Out_Valid=0.
  - In_Ready returns to 1 in the following cycle; there is no same-cycle turnaround from DONE to accept.
- Flush:
  - In CALC or DONE, the next state is IDLE, Out_Valid=0, and the result is discarded.
  - In IDLE, Flush takes priority over accept; no operation is latched that cycle.
- Input changes while not IDLE are ignored.
- In_Valid while In_Ready=0 has no effect; the producer must hold its request.

Test Plan:
- XLEN=64, MUL A=3, B=4:
  - Out_Valid exactly 65 cycles after accept.
  - Result=12.
- DIV A=40, B=5 gives 8; REM A=-7, B=2 gives -1; DIVU A=0xFFFF_FFFF_FFFF_FFFF, B=2 gives 0x7FFF_FFFF_FFFF_FFFF.
- Divide-by-zero, one cycle after accept:
  - DIV A=123, B=0 gives Result=0xFFFF_FFFF_FFFF_FFFF, DivZero=1.
  - REMU A=123, B=0 gives Result=123.
- Signed overflow: DIV A=0x8000_0000_0000_0000, B=-1 gives Result=0x8000_0000_0000_0000; REM with the same operands gives 0.
- High products:
  - MULH -1*-1 gives 0.
  - MULHU 0xFFFF_FFFF_FFFF_FFFF*0xFFFF_FFFF_FFFF_FFFF gives 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU A=-1, B=2 gives 0xFFFF_FFFF_FFFF_FFFF.
- Control events:
  - Hold Out_Ready=0 for 10 cycles in DONE: Result is stable, and In_Ready=0 throughout.
  - Rst_n low at CALC cycle 30: Out_Valid=0 and In_Ready=1 immediately.
  - Flush at CALC cycle 10: no Out_Valid, and a following MUL 5*6 returns 30.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension execute unit: radix-2 shift-add multiply
// and restoring divide on operand magnitudes with a final sign fix-up.
module mul_div_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [2:0]      Func3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Flush,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [XLEN-1:0] Result,
    output logic            DivZero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          func_q, func_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                dz_q, dz_d;

    logic                a_signed, b_signed;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                ovf;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   step_next;

    logic [2*XLEN-1:0]   prod_signed;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     quo_res;
    logic [XLEN-1:0]     rem_res;
    logic [XLEN-1:0]     final_res;

    assign In_Ready  = (state_q == IDLE);
    assign Out_Valid = (state_q == DONE);
    assign Result    = res_q;
    assign DivZero   = dz_q;

    // Operand decode: signedness, magnitudes and divide overflow detection
    always_comb begin
        a_signed = (Func3 == 3'b001) || (Func3 == 3'b010) ||
                   (Func3 == 3'b100) || (Func3 == 3'b110);
        b_signed = (Func3 == 3'b001) || (Func3 == 3'b100) ||
                   (Func3 == 3'b110);
        a_neg    = a_signed && A[XLEN-1];
        b_neg    = b_signed && B[XLEN-1];
        a_mag    = a_neg ? (~A + 1'b1) : A;
        b_mag    = b_neg ? (~B + 1'b1) : B;
        ovf      = Func3[2] && !Func3[0] &&
                   (A == MIN_NEG) && (B == ALL_ONES);
    end

    // One radix-2 iteration of either multiply or divide
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (div_trial[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
        step_next = func_q[2] ? div_next : mul_next;
    end

    // Sign fix-up and result selection from the last iteration
    always_comb begin
        prod_signed = (sa_q ^ sb_q) ? (~step_next + 1'b1) : step_next;
        mul_res     = (func_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0]
                                             : prod_signed[2*XLEN-1:XLEN];
        quo_res     = (sa_q ^ sb_q) ? (~step_next[XLEN-1:0] + 1'b1)
                                    : step_next[XLEN-1:0];
        rem_res     = sa_q ? (~step_next[2*XLEN-1:XLEN] + 1'b1)
                           : step_next[2*XLEN-1:XLEN];
        if (func_q[2]) begin
            final_res = func_q[1] ? rem_res : quo_res;
        end else begin
            final_res = mul_res;
        end
    end

    // Control FSM next-state and datapath next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        prod_d  = prod_q;
        opb_d   = opb_q;
        res_d   = res_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (Flush) begin
                    state_d = IDLE;
                end else if (In_Valid) begin
                    func_d = Func3;
                    sa_d   = a_neg;
                    sb_d   = b_neg;
                    cnt_d  = CNT_W'(XLEN);
                    if (Func3[2]) begin
                        prod_d = {{XLEN{1'b0}}, a_mag};
                        opb_d  = b_mag;
                    end else begin
                        prod_d = {{XLEN{1'b0}}, b_mag};
                        opb_d  = a_mag;
                    end
                    dz_d    = 1'b0;
                    state_d = CALC;
                    if (Func3[2] && (B == '0)) begin
                        res_d   = Func3[1] ? A : ALL_ONES;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = Func3[1] ? '0 : A;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (Flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = step_next;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = final_res;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (Flush || Out_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            prod_q  <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            prod_q  <= prod_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at XLEN=64.
// Vectors carry hand-computed results, DivZero and latency.
module tb_mul_div_unit;

    localparam int XLEN = 64;

    logic            Clk;
    logic            Rst_n;
    logic            In_Valid;
    logic            In_Ready;
    logic [2:0]      Func3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            Flush;
    logic            Out_Valid;
    logic            Out_Ready;
    logic [XLEN-1:0] Result;
    logic            DivZero;

    int checks;
    int failures;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Func3     (Func3),
        .A         (A),
        .B         (B),
        .Flush     (Flush),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Result    (Result),
        .DivZero   (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [2:0] f,
                           input logic [63:0] a,
                           input logic [63:0] b);
        @(negedge Clk);
        Func3    = f;
        A        = a;
        B        = b;
        In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic run_op(input string tag,
                          input logic [2:0] f,
                          input logic [63:0] a,
                          input logic [63:0] b,
                          input logic [63:0] er,
                          input logic edz,
                          input int elat);
        int n;
        present(f, a, b);
        n = 1;
        while (!Out_Valid && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_res"}, Result, er);
        chk({tag, "_dz"}, {63'd0, DivZero}, {63'd0, edz});
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int n;
        int seen;
        checks    = 0;
        failures  = 0;
        Rst_n     = 1'b0;
        In_Valid  = 1'b0;
        Func3     = 3'b000;
        A         = '0;
        B         = '0;
        Flush     = 1'b0;
        Out_Ready = 1'b1;
        #12;
        chk("rst_in_ready", {63'd0, In_Ready}, 64'd1);
        chk("rst_out_valid", {63'd0, Out_Valid}, 64'd0);
        chk("rst_result", Result, 64'd0);
        chk("rst_divzero", {63'd0, DivZero}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        run_op("mul_3x4", 3'b000, 64'd3, 64'd4, 64'd12, 1'b0, 65);
        run_op("mul_neg", 3'b000, -64'sd3, 64'd4,
               -64'sd12, 1'b0, 65);
        run_op("div_40_5", 3'b100, 64'd40, 64'd5, 64'd8, 1'b0, 65);
        run_op("div_m40_5", 3'b100, -64'sd40, 64'd5,
               -64'sd8, 1'b0, 65);
        run_op("rem_m7_2", 3'b110, -64'sd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
        run_op("divu_max", 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 65);
        run_op("remu_17_5", 3'b111, 64'd17, 64'd5, 64'd2, 1'b0, 65);
        run_op("div_by0", 3'b100, 64'd123, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        run_op("remu_by0", 3'b111, 64'd123, 64'd0, 64'd123, 1'b1, 1);
        run_op("div_ovf", 3'b100, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b0, 1);
        run_op("rem_ovf", 3'b110, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1);
        run_op("mulh_m1", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65);
        run_op("mulhu_max", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
        run_op("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);

        // Backpressure: result held while Out_Ready is low
        Out_Ready = 1'b0;
        present(3'b000, 64'd7, 64'd9);
        n = 1;
        while (!Out_Valid && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("bp_lat", 64'(n), 64'd65);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            chk("bp_valid", {63'd0, Out_Valid}, 64'd1);
            chk("bp_result", Result, 64'd63);
            chk("bp_in_ready", {63'd0, In_Ready}, 64'd0);
        end
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        chk("bp_release_valid", {63'd0, Out_Valid}, 64'd0);
        chk("bp_release_ready", {63'd0, In_Ready}, 64'd1);

        // Asynchronous reset in the middle of a divide
        present(3'b100, 64'd1000, 64'd3);
        repeat (29) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, Out_Valid}, 64'd0);
        chk("rst_mid_ready", {63'd0, In_Ready}, 64'd1);
        chk("rst_mid_result", Result, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(posedge Clk);
            #1;
            if (Out_Valid) seen++;
        end
        chk("rst_mid_no_out", 64'(seen), 64'd0);

        // Flush during CALC discards the operation
        present(3'b000, 64'd11, 64'd13);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        chk("flush_ready", {63'd0, In_Ready}, 64'd1);
        seen = 0;
        repeat (70) begin
            @(posedge Clk);
            #1;
            if (Out_Valid) seen++;
        end
        chk("flush_no_out", 64'(seen), 64'd0);
        run_op("mul_after_flush", 3'b000, 64'd5, 64'd6,
               64'd30, 1'b0, 65);

        // Flush in IDLE wins over a presented operation
        @(negedge Clk);
        Func3    = 3'b100;
        A        = 64'd9;
        B        = 64'd0;
        In_Valid = 1'b1;
        Flush    = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        Flush    = 1'b0;
        chk("idle_flush_ready", {63'd0, In_Ready}, 64'd1);
        chk("idle_flush_valid", {63'd0, Out_Valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
